// File: rtl/dual_lane_mac.sv
// Two-lane signed MAC: each frame sums N_TAPS products of a shared sample with per-lane coefficients.
// Latency: result pair one cycle after the last tap is accepted; done one cycle after the final result.
module dual_lane_mac #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 18,
    parameter int N_TAPS   = 8,
    parameter int N_GROUPS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [IN_W-1:0]  a_in,
    input  logic [IN_W-1:0]  b1_in,
    input  logic [IN_W-1:0]  b2_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] data1,
    output logic [OUT_W-1:0] data2,
    output logic             valid_out,
    output logic             done
);

    localparam int PROD_W = 2 * IN_W;
    localparam int ACC_W  = PROD_W + $clog2(N_TAPS);
    localparam int SAT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam int TAP_W  = $clog2(N_TAPS);
    localparam int GRP_W  = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

    localparam logic [SAT_W-1:0] SAT_MAX = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [SAT_W-1:0] SAT_MIN = {{(SAT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc1_q, acc1_d, acc2_q, acc2_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [OUT_W-1:0]   data1_q, data1_d, data2_q, data2_d;
    logic               valid_out_q, valid_out_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;

    logic [PROD_W-1:0]  a_ext, b1_ext, b2_ext, p1, p2;
    logic [ACC_W-1:0]   sum1, sum2;

    // Sign-extend to a width that cannot overflow, then clamp into OUT_W.
    function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] v);
        logic [SAT_W-1:0] ext;
        ext = {{(SAT_W-ACC_W){v[ACC_W-1]}}, v};
        if ($signed(ext) > $signed(SAT_MAX)) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if ($signed(ext) < $signed(SAT_MIN)) begin
            sat = SAT_MIN[OUT_W-1:0];
        end else begin
            sat = ext[OUT_W-1:0];
        end
    endfunction

    always_comb begin
        a_ext  = {{IN_W{a_in[IN_W-1]}}, a_in};
        b1_ext = {{IN_W{b1_in[IN_W-1]}}, b1_in};
        b2_ext = {{IN_W{b2_in[IN_W-1]}}, b2_in};
        p1     = a_ext * b1_ext;
        p2     = a_ext * b2_ext;
        sum1   = acc1_q + {{(ACC_W-PROD_W){p1[PROD_W-1]}}, p1};
        sum2   = acc2_q + {{(ACC_W-PROD_W){p2[PROD_W-1]}}, p2};

        state_d     = state_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        tap_d       = tap_q;
        grp_d       = grp_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        valid_out_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // The done pulse is visible while already back in IDLE; a start
                // seen alongside it belongs to the finished run and is dropped.
                if (start && !done_q) begin
                    acc1_d  = '0;
                    acc2_d  = '0;
                    tap_d   = '0;
                    grp_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if (tap_q == TAP_W'(N_TAPS - 1)) begin
                        data1_d     = sat(sum1);
                        data2_d     = sat(sum2);
                        valid_out_d = 1'b1;
                        acc1_d      = '0;
                        acc2_d      = '0;
                        tap_d       = '0;
                        grp_d       = grp_q + 1'b1;
                        if (grp_q == GRP_W'(N_GROUPS - 1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        acc1_d = sum1;
                        acc2_d = sum2;
                        tap_d  = tap_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc1_q      <= '0;
            acc2_q      <= '0;
            tap_q       <= '0;
            grp_q       <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            valid_out_q <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            tap_q       <= tap_d;
            grp_q       <= grp_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            valid_out_q <= valid_out_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign data1     = data1_q;
    assign data2     = data2_q;
    assign valid_out = valid_out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dual_lane_mac.sv
// Directed bench for dual_lane_mac: frames, saturation, stalls, full run, reset and ignored controls.
module tb_dual_lane_mac;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  a_in, b1_in, b2_in;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] data1, data2;
    logic        valid_out;
    logic        done;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int vo_cnt  = 0;
    int b2b_cnt = 0;
    int vo_bad  = 0;
    logic prev_vo = 1'b0;
    logic mon_en  = 1'b0;

    dual_lane_mac dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a_in      (a_in),
        .b1_in     (b1_in),
        .b2_in     (b2_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data1     (data1),
        .data2     (data2),
        .valid_out (valid_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out) begin
            vo_cnt = vo_cnt + 1;
            if (prev_vo) b2b_cnt = b2b_cnt + 1;
            if (mon_en && (data1 !== 18'd28 || data2 !== 18'd28)) vo_bad = vo_bad + 1;
        end
        prev_vo = valid_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b1, input logic [7:0] b2);
        a_in = a; b1_in = b1; b2_in = b2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int stall_cnt [8];
        int t0, vo_base, b2b_base;

        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        a_in = '0; b1_in = '0; b2_in = '0;
        tick(); tick();
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_data1",     {14'd0, data1},     32'd0);
        check("rst_data2",     {14'd0, data2},     32'd0);
        reset_n = 1'b1;

        // in_valid while idle must not accumulate anything
        a_in = 8'd5; b1_in = 8'd5; b2_in = 8'd5; in_valid = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0;
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        check("idle_no_vo",    vo_cnt,            32'd0);

        pulse_start();
        check("start_in_ready", {31'd0, in_ready}, 32'd1);

        // frame 1: basic
        for (int i = 0; i < 7; i++) send(8'd1, 8'd2, 8'hFD);
        check("basic_early_vo", {31'd0, valid_out}, 32'd0);
        send(8'd1, 8'd2, 8'hFD);
        check("basic_vo",    {31'd0, valid_out}, 32'd1);
        check("basic_data1", {14'd0, data1},     32'h00010);
        check("basic_data2", {14'd0, data2},     32'h3FFE8);
        check("basic_ready", {31'd0, in_ready},  32'd1);
        tick();
        check("basic_vo_pulse", {31'd0, valid_out}, 32'd0);
        check("hold_data1",     {14'd0, data1},     32'h00010);

        // frame 2: lane 1 saturates positive, lane 2 stays in range
        for (int i = 0; i < 8; i++) send(8'h80, 8'h80, 8'h7F);
        check("sat_vo",    {31'd0, valid_out}, 32'd1);
        check("sat_data1", {14'd0, data1},     32'h1FFFF);
        check("sat_data2", {14'd0, data2},     32'h20400);

        // frame 3: three stall cycles, with start toggled mid-run
        foreach (stall_cnt[i]) stall_cnt[i] = 0;
        for (int s = 0; s < 3; s++) stall_cnt[$urandom_range(0, 6)]++;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            start = (i == 2);
            send(8'd1, 8'd2, 8'hFD);
            for (int s = 0; s < stall_cnt[i]; s++) begin
                start = 1'b1;
                tick();
            end
            start = 1'b0;
        end
        check("stall_latency", cyc - t0,            32'd11);
        check("stall_vo",      {31'd0, valid_out},  32'd1);
        check("stall_data1",   {14'd0, data1},      32'h00010);
        check("stall_data2",   {14'd0, data2},      32'h3FFE8);

        // frames 4..8 close the run
        for (int f = 0; f < 5; f++)
            for (int i = 0; i < 8; i++) send(8'(i), 8'd1, 8'd1);
        check("last_vo",       {31'd0, valid_out}, 32'd1);
        check("last_ready",    {31'd0, in_ready},  32'd0);
        check("last_no_done",  {31'd0, done},      32'd0);
        start = 1'b1;
        tick();
        check("done_pulse",    {31'd0, done},      32'd1);
        tick();
        check("done_start_ignored", {31'd0, in_ready}, 32'd0);
        check("done_one_cycle",     {31'd0, done},     32'd0);
        tick();
        start = 1'b0;
        check("start_after_done", {31'd0, in_ready}, 32'd1);

        // full run: a = tap index, both coefficients 1 -> 28 per frame
        vo_base = vo_cnt; b2b_base = b2b_cnt; mon_en = 1'b1;
        for (int f = 0; f < 8; f++)
            for (int i = 0; i < 8; i++) send(8'(i), 8'd1, 8'd1);
        tick();
        mon_en = 1'b0;
        check("run_done",      {31'd0, done},     32'd1);
        check("run_vo_count",  vo_cnt - vo_base,  32'd8);
        check("run_b2b",       b2b_cnt - b2b_base, 32'd0);
        check("run_vo_data",   vo_bad,            32'd0);
        tick();
        check("run_ready_after", {31'd0, in_ready}, 32'd0);
        check("run_done_clear",  {31'd0, done},     32'd0);

        // reset in the middle of a frame
        pulse_start();
        vo_base = vo_cnt;
        for (int i = 0; i < 5; i++) send(8'd7, 8'd7, 8'd7);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        check("mid_rst_no_vo", vo_cnt - vo_base,  32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_data1", {14'd0, data1},    32'd0);
        pulse_start();
        for (int i = 0; i < 8; i++) send(8'd1, 8'd2, 8'hFD);
        check("restart_vo",    {31'd0, valid_out}, 32'd1);
        check("restart_data1", {14'd0, data1},     32'h00010);
        check("restart_data2", {14'd0, data2},     32'h3FFE8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
